pk_host_bridge: RTL and testbench

Byte-stream command front-end for the password-keeper core. Accepts framed STORE/FETCH commands over a valid/ready byte interface and assembles the 128-bit account, master_key and password words. Drives the core's go/done handshake, captures password_enc when the core finishes, and returns a response byte stream (ack, 16-byte encrypted password, or error code). Sits directly upstream of the core wrapper and owns all of its control inputs except the core's own rst.

---
 rtl/pk_pkg.sv | 10 +
 rtl/pk_resp_serializer.sv | 39 +++
 rtl/pk_host_bridge.sv | 109 ++++++++++
 tb/tb_pk_host_bridge.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pk_pkg.sv
// pk_pkg: shared opcodes, response codes, bridge states and block type
package pk_pkg;
   localparam logic [7:0] OP_STORE    = 8'h01;
   localparam logic [7:0] OP_FETCH    = 8'h02;
   localparam logic [7:0] ACK         = 8'hA5;
   localparam logic [7:0] ERR_OPCODE  = 8'hEE;
   localparam logic [7:0] ERR_TIMEOUT = 8'hEF;
   typedef enum logic [2:0] {IDLE, LOAD, START, FINISH, RESP} state_t;
   typedef logic [127:0] block_t;
endpackage

// File: rtl/pk_resp_serializer.sv
// pk_resp_serializer: emits a 16-byte block or a single byte, MSB first, under valid/ready
module pk_resp_serializer
   import pk_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load_word,
   input  logic       load_byte,
   input  block_t     word,
   input  logic [7:0] code,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       last
);
   block_t sr;
   logic [3:0] left;
   assign out_data = sr[127:120];
   assign last = left == 4'd0;
   // shift register advancing one byte per accepted output byte
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sr <= '0;
         left <= '0;
         out_valid <= 1'b0;
      end else if (load_word) begin
         sr <= word;
         left <= 4'd15;
         out_valid <= 1'b1;
      end else if (load_byte) begin
         sr <= {code, 120'd0};
         left <= '0;
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         sr <= {sr[119:0], 8'd0};
         left <= left - 4'd1;
         out_valid <= left != 4'd0;
      end
endmodule

// File: rtl/pk_host_bridge.sv
// pk_host_bridge: framed STORE/FETCH byte front-end driving the password-keeper core
module pk_host_bridge
   import pk_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [7:0]   out_data,
   output logic         busy,
   output logic         go,
   output logic [127:0] account,
   output logic [127:0] master_key,
   output logic [127:0] password,
   input  logic         done,
   input  logic [127:0] password_enc
);
   state_t state, nxt;
   logic live, store, done_q, accept, expired, ld_word, ld_byte, ser_last;
   logic [5:0] cnt;
   logic [31:0] tmr;
   logic [7:0] code;
   assign in_ready = live && (state == IDLE || state == LOAD);
   assign accept = in_valid && in_ready;
   assign busy = state != IDLE;
   assign go = state == START || state == FINISH;
   assign expired = go && tmr == 32'(TIMEOUT_CYCLES - 1);
   // next state and serializer load requests
   always_comb begin
      nxt = state;
      ld_word = 1'b0;
      ld_byte = 1'b0;
      code = ACK;
      case (state)
         IDLE:
            if (accept) begin
               if (in_data == OP_STORE || in_data == OP_FETCH) nxt = LOAD;
               else begin
                  nxt = RESP;
                  ld_byte = 1'b1;
                  code = ERR_OPCODE;
               end
            end
         LOAD: if (accept && cnt == (store ? 6'd47 : 6'd31)) nxt = START;
         START, FINISH:
            if (expired) begin
               nxt = RESP;
               ld_byte = 1'b1;
               code = ERR_TIMEOUT;
            end else if (state == START && done) nxt = FINISH;
            else if (state == FINISH && done_q && !done) begin
               nxt = RESP;
               ld_word = !store;
               ld_byte = store;
            end
         RESP: if (out_valid && out_ready && ser_last) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   // state register; live holds in_ready low until the first edge after reset
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         live <= 1'b0;
      end else begin
         state <= nxt;
         live <= 1'b1;
      end
   // frame assembly, done edge sampling and go timeout counter
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0;
         store <= 1'b0;
         done_q <= 1'b0;
         tmr <= '0;
         account <= '0;
         master_key <= '0;
         password <= '0;
      end else begin
         done_q <= done;
         tmr <= go ? tmr + 32'd1 : '0;
         if (state == IDLE && accept) begin
            cnt <= '0;
            store <= in_data == OP_STORE;
         end else if (state == LOAD && accept) begin
            cnt <= cnt + 6'd1;
            if (cnt < 6'd16) account <= {account[119:0], in_data};
            else if (cnt < 6'd32) master_key <= {master_key[119:0], in_data};
            else password <= {password[119:0], in_data};
         end
      end
   pk_resp_serializer ser (
      .clk(clk),
      .rst(rst),
      .load_word(ld_word),
      .load_byte(ld_byte),
      .word(password_enc),
      .code(code),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .last(ser_last)
   );
endmodule

// File: tb/tb_pk_host_bridge.sv
// tb_pk_host_bridge: scoreboard bench for the pk_host_bridge command front-end
module tb_pk_host_bridge;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, done;
   logic [7:0] in_data = 8'h00;
   logic in_ready, out_valid, busy, go;
   logic [7:0] out_data;
   logic [127:0] account, master_key, password, password_enc = '0;
   localparam logic [127:0] A1 = 128'h5468617473206D79204B756E67204675;
   localparam logic [127:0] K1 = 128'h54776F204F696E652054776F6E65204E;
   localparam logic [127:0] P1 = 128'h65686689abc365204E696E652054776F;
   localparam logic [127:0] A2 = 128'h52792047204B4686106D677374756E65;
   localparam logic [127:0] K2 = 128'h7752547E76F204E65205404F66F6E696;
   localparam logic [127:0] E1 = 128'h1972f0b02b2017c8a568fab814f45c12;
   localparam logic [127:0] P2 = 128'h0123456789abcdef0011223344556677;
   localparam logic [127:0] E2 = 128'hfedcba98765432100f1e2d3c4b5a6978;
   int checks = 0, errors = 0, cyc = 0, go_rises = 0, go_rise_cyc = 0, ov_cyc = 0, stub_delay = 20, r0;
   bit rand_ready = 0, stalled = 0, prev_go = 0, prev_ov = 0;
   logic [7:0] held;
   logic [383:0] cw;
   logic [7:0] exp_q[$];
   logic [383:0] core_q[$];

   pk_host_bridge #(.TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy), .go(go),
      .account(account), .master_key(master_key), .password(password),
      .done(done), .password_enc(password_enc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_data = b;
      while (!in_ready) begin
         n++;
         if (n > 500) begin
            checks++;
            errors++;
            $display("FAIL send_wait: in_ready stuck low for byte %h", b);
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic frame(input logic [7:0] op, input logic [127:0] a, input logic [127:0] k,
                        input logic [127:0] p, input bit st);
      send(op);
      for (int i = 0; i < 16; i++) send(a[127-8*i -: 8]);
      for (int i = 0; i < 16; i++) send(k[127-8*i -: 8]);
      if (st) for (int i = 0; i < 16; i++) send(p[127-8*i -: 8]);
   endtask

   task automatic push_word(input logic [127:0] w);
      for (int i = 0; i < 16; i++) exp_q.push_back(w[127-8*i -: 8]);
   endtask

   task automatic wait_done();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 128'(n >= 3000), 0);
   endtask

   // monitor: go/out_valid edges, stall stability and scoreboard pops
   initial forever begin
      @(negedge clk);
      if (go && !prev_go) begin
         go_rises++;
         go_rise_cyc = cyc;
      end
      if (out_valid && !prev_ov) ov_cyc = cyc;
      prev_go = go;
      prev_ov = out_valid;
      if (out_valid) check("in_ready_during_resp", in_ready, 0);
      if (stalled) begin
         check("stall_valid", out_valid, 1);
         check("stall_hold", out_data, held);
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %h expected none", out_data);
         end else check("resp_byte", out_data, exp_q.pop_front());
      end
   end

   // core stub: done after stub_delay cycles, held 3 cycles; negative delay never answers
   initial begin
      done = 1'b0;
      forever begin
         @(posedge go);
         if (stub_delay >= 0) begin
            repeat (stub_delay) @(negedge clk);
            check("go_at_done", go, 1);
            if (core_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL core_expect: got go with no expected command");
            end else begin
               cw = core_q.pop_front();
               check("core_account", account, cw[383:256]);
               check("core_master_key", master_key, cw[255:128]);
               check("core_password", password, cw[127:0]);
            end
            done = 1'b1;
            repeat (3) @(negedge clk);
            done = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_go", go, 0);
      check("rst_account", account, 0);
      check("rst_master_key", master_key, 0);
      check("rst_password", password, 0);
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_rst", in_ready, 1);
      send(8'h01);
      for (int i = 0; i < 10; i++) send(8'hFF);
      #2 rst = 1'b1;
      #1;
      check("abort_go", go, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_account", account, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      stub_delay = 20;
      r0 = go_rises;
      core_q.push_back({A1, K1, P1});
      exp_q.push_back(8'hA5);
      frame(8'h01, A1, K1, P1, 1);
      wait_done();
      check("store_go_rises", go_rises - r0, 1);
      password_enc = E1;
      rand_ready = 1;
      core_q.push_back({A2, K2, P1});
      push_word(E1);
      frame(8'h02, A2, K2, '0, 0);
      wait_done();
      rand_ready = 0;
      r0 = go_rises;
      exp_q.push_back(8'hEE);
      send(8'h07);
      wait_done();
      check("badop_no_go", go_rises - r0, 0);
      stub_delay = -1;
      exp_q.push_back(8'hEF);
      frame(8'h02, A1, K1, '0, 0);
      wait_done();
      check("timeout_latency", ov_cyc - go_rise_cyc, 64);
      check("timeout_go_low", go, 0);
      check("timeout_idle", busy, 0);
      stub_delay = 5;
      r0 = go_rises;
      password_enc = E2;
      core_q.push_back({A1, K1, P2});
      exp_q.push_back(8'hA5);
      core_q.push_back({A2, K2, P2});
      push_word(E2);
      frame(8'h01, A1, K1, P2, 1);
      frame(8'h02, A2, K2, '0, 0);
      wait_done();
      check("b2b_go_rises", go_rises - r0, 2);
      check("core_q_empty", core_q.size(), 0);
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
